// File: rtl/inverse_scan_pkg.sv
// Shared types and scan tables for the inverse scan block.
// The RTL and the reference model both use these tables.
package inverse_scan_pkg;

  localparam int COEF_W = 12;
  localparam int BLK_N  = 64;

  typedef enum logic [1:0] {
    SCAN_ZZ  = 2'd0,
    SCAN_AH  = 2'd1,
    SCAN_AV  = 2'd2,
    SCAN_RSV = 2'd3
  } scan_e;

  typedef logic [5:0] scan_tbl_t [64];

  localparam scan_tbl_t ZZ_TBL = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam scan_tbl_t AH_TBL = '{
     0,  1,  2,  3,  8,  9, 16, 17,
    10, 11,  4,  5,  6,  7, 15, 14,
    13, 12, 19, 18, 24, 25, 32, 33,
    26, 27, 20, 21, 22, 23, 28, 29,
    30, 31, 34, 35, 40, 41, 48, 49,
    42, 43, 36, 37, 38, 39, 44, 45,
    46, 47, 50, 51, 56, 57, 58, 59,
    52, 53, 54, 55, 60, 61, 62, 63
  };

  localparam scan_tbl_t AV_TBL = '{
     0,  8, 16, 24,  1,  9,  2, 10,
    17, 25, 32, 40, 48, 56, 57, 49,
    41, 33, 26, 18,  3, 11,  4, 12,
    19, 27, 34, 42, 50, 58, 35, 43,
    51, 59, 20, 28,  5, 13,  6, 14,
    21, 29, 36, 44, 52, 60, 37, 45,
    53, 61, 22, 30,  7, 15, 23, 31,
    38, 46, 54, 62, 39, 47, 55, 63
  };

  // Reserved mode falls back to zigzag.
  function automatic logic [5:0] scan_addr(
    input scan_e      s,
    input logic [5:0] k
  );
    logic [5:0] a;
    case (s)
      SCAN_AH: a = AH_TBL[k];
      SCAN_AV: a = AV_TBL[k];
      default: a = ZZ_TBL[k];
    endcase
    return a;
  endfunction

endpackage

// File: rtl/inverse_scan_if.sv
// Scan-order input and raster-order output streams
// of the inverse scan block.
interface inverse_scan_if #(
  parameter int COEF_W = inverse_scan_pkg::COEF_W
);

  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_coef;
  logic [1:0]        in_scan;
  logic              out_valid;
  logic              out_ready;
  logic [COEF_W-1:0] out_coef;
  logic              out_last;

  modport slave (
    input  in_valid, in_coef, in_scan, out_ready,
    output in_ready, out_valid, out_coef, out_last
  );

  modport master (
    output in_valid, in_coef, in_scan, out_ready,
    input  in_ready, out_valid, out_coef, out_last
  );

endinterface

// File: rtl/scan_bank_ram.sv
// Two-bank coefficient store: one write port and one
// registered read port; the bank select is the address MSB.
module scan_bank_ram #(
  parameter int COEF_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [6:0]        waddr,
  input  logic [COEF_W-1:0] wdata,
  input  logic              re,
  input  logic [6:0]        raddr,
  output logic [COEF_W-1:0] rdata
);

  logic [COEF_W-1:0] mem [128];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the output holding stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inverse_scan.sv
// Inverse scan: reorders a block of 64 coefficients from
// scan order to raster order through ping-pong banks.
module inverse_scan #(
  parameter int COEF_W = inverse_scan_pkg::COEF_W,
  parameter int BLK_N  = inverse_scan_pkg::BLK_N
) (
  input logic           clk,
  input logic           rst_n,
  inverse_scan_if.slave bus
);

  import inverse_scan_pkg::*;

  localparam logic [5:0] LAST = 6'(BLK_N - 1);

  logic [5:0]        wr_cnt;
  logic [5:0]        rd_ptr;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  scan_e             blk_scan;
  scan_e             cur_scan;
  logic [5:0]        wr_addr;
  logic              wr_en;
  logic              wr_last;
  logic              rd_en;
  logic              rd_last;
  logic              advance;
  logic              out_valid_q;
  logic              out_last_q;
  logic [COEF_W-1:0] rd_data;

  assign bus.in_ready = !full[wr_bank];
  assign wr_en   = bus.in_valid && !full[wr_bank];
  assign wr_last = wr_en && (wr_cnt == LAST);

  assign cur_scan = (wr_cnt == '0) ?
                    scan_e'(bus.in_scan) : blk_scan;
  assign wr_addr  = scan_addr(cur_scan, wr_cnt);

  assign advance = !out_valid_q || bus.out_ready;
  assign rd_en   = full[rd_bank] && advance;
  assign rd_last = rd_en && (rd_ptr == LAST);

  // A bank is released once its last word is in the output
  // register, which holds it; this keeps the input streaming.
  always_comb begin
    full_nxt = full;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      blk_scan <= SCAN_ZZ;
    end else if (wr_en) begin
      wr_cnt <= wr_last ? '0 : wr_cnt + 6'd1;
      if (wr_cnt == '0) blk_scan <= cur_scan;
      if (wr_last) wr_bank <= !wr_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full        <= '0;
      rd_ptr      <= '0;
      rd_bank     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (rd_en) begin
        rd_ptr <= rd_last ? '0 : rd_ptr + 6'd1;
      end
      if (rd_last) rd_bank <= !rd_bank;
      if (advance) begin
        out_valid_q <= rd_en;
        out_last_q  <= rd_last;
      end
    end
  end

  scan_bank_ram #(
    .COEF_W(COEF_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr ({wr_bank, wr_addr}),
    .wdata (bus.in_coef),
    .re    (rd_en),
    .raddr ({rd_bank, rd_ptr}),
    .rdata (rd_data)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_coef  = rd_data;

endmodule

// File: tb/tb_inverse_scan.sv
// Directed bench for inverse_scan: scan tables, latency,
// streaming, back-pressure, random traffic and mid-block reset.
module tb_inverse_scan;

  import inverse_scan_pkg::*;

  localparam int NRB = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] rmode;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hold_viol = 0;
  int rdy_drop = 0;

  logic [31:0] obq [$];
  bit          olq [$];
  int          ocyc [$];

  logic              hv;
  logic              hr;
  logic              hl;
  logic [COEF_W-1:0] hc;

  inverse_scan_if #(.COEF_W(COEF_W)) bus ();

  inverse_scan dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rmode == 2'd2) bus.out_ready = 1'($urandom_range(1));
    else bus.out_ready = rmode[0];
  end

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      obq.push_back(32'(bus.out_coef));
      olq.push_back(bus.out_last);
      ocyc.push_back(cyc);
    end
    if (rst_n && hv && !hr) begin
      if (!(bus.out_valid === 1'b1 && bus.out_coef === hc &&
            bus.out_last === hl))
        hold_viol++;
    end
    hv = rst_n && bus.out_valid;
    hr = bus.out_ready;
    hc = bus.out_coef;
    hl = bus.out_last;
    if (rst_n && bus.in_ready !== 1'b1) rdy_drop++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(
    input logic [1:0] sc, input int base, input int r
  );
    logic [31:0] v;
    v = '1;
    for (int k = 0; k < 64; k++)
      if (int'(scan_addr(scan_e'(sc), 6'(k))) == r)
        v = 32'(base + k);
    return {20'b0, v[11:0]};
  endfunction

  task automatic chk(
    input string tag, input logic [31:0] obs, input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(
    input int n, input int base, input logic [1:0] sc,
    input int vpct, input int budget, output int got
  );
    int nc;
    got = 0;
    nc = 0;
    while (got < n && nc < budget) begin
      bus.in_valid = ($urandom_range(99) < vpct);
      bus.in_coef  = 12'(base + got);
      bus.in_scan  = (got % 64 == 0) ? sc : 2'($urandom_range(3));
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) got++;
      @(posedge clk);
      #1;
      nc++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_outs(
    input string tag, input int target, input int budget
  );
    int n;
    n = 0;
    while (obq.size() < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(obq.size() >= target), 1);
  endtask

  initial begin
    int b, got, tot, errs, d0, h0, lastn;
    logic [1:0] rsc [NRB];
    int rbase [NRB];

    rst_n = 1'b0;
    rmode = 2'd1;
    bus.in_valid = 1'b0;
    bus.in_coef  = '0;
    bus.in_scan  = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_out_coef", 32'(bus.out_coef), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 1);

    // zigzag block and fill-to-output latency
    b = obq.size();
    push(64, 0, 2'd0, 100, 200, got);
    chk("zz_accept", 32'(got), 64);
    @(negedge clk);
    chk("lat_c1", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_c2", 32'(bus.out_valid), 1);
    wait_outs("zz_tmo", b + 64, 200);
    chk("zz_out0", obq[b+0], 0);
    chk("zz_out1", obq[b+1], 1);
    chk("zz_out2", obq[b+2], 5);
    chk("zz_out3", obq[b+3], 6);
    chk("zz_out8", obq[b+8], 2);
    chk("zz_out16", obq[b+16], 3);
    chk("zz_out63", obq[b+63], 63);
    lastn = 0;
    for (int i = 0; i < 64; i++) if (olq[b+i]) lastn++;
    chk("zz_last_cnt", 32'(lastn), 1);
    chk("zz_last_pos", 32'(olq[b+63]), 1);

    b = obq.size();
    push(64, 0, 2'd1, 100, 200, got);
    wait_outs("ah_tmo", b + 64, 200);
    chk("ah_out8", obq[b+8], 4);
    chk("ah_out3", obq[b+3], 3);
    chk("ah_out17", obq[b+17], 7);

    b = obq.size();
    push(64, 0, 2'd2, 100, 200, got);
    wait_outs("av_tmo", b + 64, 200);
    chk("av_out8", obq[b+8], 1);
    chk("av_out1", obq[b+1], 4);
    chk("av_out24", obq[b+24], 3);

    b = obq.size();
    push(64, 0, 2'd3, 100, 200, got);
    wait_outs("rsv_tmo", b + 64, 200);
    chk("rsv_out2", obq[b+2], 5);
    chk("rsv_out16", obq[b+16], 3);

    // four back-to-back blocks
    b = obq.size();
    d0 = rdy_drop;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      push(64, 64 * i, 2'd0, 100, 200, got);
      tot += got;
    end
    chk("b2b_accept", 32'(tot), 256);
    chk("b2b_rdy_drops", 32'(rdy_drop - d0), 0);
    wait_outs("b2b_tmo", b + 256, 400);
    chk("b2b_span", 32'(ocyc[b+255] - ocyc[b]), 255);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (obq[b+i] !== model(2'd0, 64 * (i / 64), i % 64)) errs++;
      if (olq[b+i] !== (i % 64 == 63)) errs++;
    end
    chk("b2b_data", 32'(errs), 0);

    // output stalled for 200 cycles
    rmode = 2'd0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    b = obq.size();
    h0 = hold_viol;
    push(192, 1000, 2'd0, 100, 200, got);
    chk("stall_accept", 32'(got), 128);
    chk("stall_in_ready", 32'(bus.in_ready), 0);
    chk("stall_out_valid", 32'(bus.out_valid), 1);
    chk("stall_no_out", 32'(obq.size()), 32'(b));
    rmode = 2'd1;
    wait_outs("stall_tmo", b + 128, 300);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_count", 32'(obq.size()), 32'(b + 128));
    errs = 0;
    for (int i = 0; i < 128; i++)
      if (obq[b+i] !== model(2'd0, 1000 + 64 * (i / 64), i % 64))
        errs++;
    chk("stall_data", 32'(errs), 0);
    chk("stall_hold", 32'(hold_viol - h0), 0);

    // random traffic on both sides
    rmode = 2'd2;
    b = obq.size();
    h0 = hold_viol;
    tot = 0;
    for (int i = 0; i < NRB; i++) begin
      rsc[i]   = 2'($urandom_range(3));
      rbase[i] = int'($urandom_range(3000));
      push(64, rbase[i], rsc[i], 70, 2000, got);
      tot += got;
    end
    chk("rand_accept", 32'(tot), 32'(64 * NRB));
    rmode = 2'd1;
    wait_outs("rand_tmo", b + 64 * NRB, 400);
    errs = 0;
    for (int i = 0; i < 64 * NRB; i++) begin
      if (obq[b+i] !== model(rsc[i/64], rbase[i/64], i % 64)) errs++;
      if (olq[b+i] !== (i % 64 == 63)) errs++;
    end
    chk("rand_data", 32'(errs), 0);
    chk("rand_hold", 32'(hold_viol - h0), 0);

    // reset at input 30 of the second block
    rmode = 2'd0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    push(94, 2000, 2'd0, 100, 300, got);
    chk("rst_pre_accept", 32'(got), 94);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(bus.out_valid), 0);
    chk("rst_mid_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    rmode = 2'd1;
    @(posedge clk);
    #1;
    b = obq.size();
    push(64, 3000, 2'd2, 100, 200, got);
    wait_outs("rst_tmo", b + 64, 200);
    repeat (20) @(posedge clk);
    #1;
    chk("rst_residue", 32'(obq.size()), 32'(b + 64));
    errs = 0;
    for (int i = 0; i < 64; i++)
      if (obq[b+i] !== model(2'd2, 3000, i)) errs++;
    chk("rst_fresh_data", 32'(errs), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
